sid_dca_scheduler: RTL and testbench
====================================

# sid_dca_scheduler

Time-multiplexed amplitude/mix engine for a three-voice SID. It replaces three per-voice wave×envelope multipliers with one shared multiplier, sequenced once per `ce_1m` sample tick. It accumulates the voices into a direct bus and a filter-send bus, adds the filter return, applies the 4-bit master volume, and emits one signed sample per tick. It sits between the three `sid_voice_8580` instances (wave/envelope outputs) and the filter/output stage.

## Interface
Parameters:
- none (widths fixed in `sid_dca_pkg`)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_1m  in  1  one-clock sample tick; ≥8 clocks apart in normal use
- wave0, wave1, wave2  in  12 each  voice waveform, unsigned offset-binary
- env0, env1, env2  in  8 each  voice envelope, unsigned
- filt_en  in  3  bit n=1 routes voice n to the filter send instead of direct
- voice3_off  in  1  mutes voice 2 from the direct bus only
- volume  in  4  master volume, 0..15
- filter_return  in  14  signed output of the filter
- direct_sum  out  14  signed sum of directly routed voices
- filter_sum  out  14  signed sum of filter-routed voices
- audio_out  out  16  signed final sample
- sample_valid  out  1  one-clock pulse when all outputs update
- busy  out  1  high whenever state≠IDLE
- overrun  out  1  sticky; a tick arrived while busy

## Operation
- States: IDLE, V0, V1, V2, MIX, VOL.
- **IDLE:** on `ce_1m=1`, snapshot all wave/env/filt_en/voice3_off/volume/filter_return, clear both accumulators, and go to V0. Otherwise stay.
- **Vn (n=0,1,2):**
  - s = wave_n − 2048 as 12-bit signed.
  - p = s × env_n as 20-bit signed (range −522240..521985, no overflow).
  - v = p[19:8], arithmetic (floor).
  - If filt_en[n], add v to filt_acc. Else add v to dir_acc, unless n=2 and voice3_off.
  - Accumulators are 14-bit signed and cannot overflow (|3×2040| < 8192).
  - Advance to the next state.
- **MIX:** m = dir_acc + filter_return, 15-bit signed. Go to VOL.
- **VOL:**
  - audio_out ← sign-extend16((m × volume) >>> 4), 19-bit product, floor.
  - direct_sum ← dir_acc; filter_sum ← filt_acc.
  - Assert sample_valid. Go to IDLE.
- The multiplier is used only in states V0–V2 and VOL.
- **ce_1m while busy:** the tick is ignored and overrun←1. The sequence in progress is unaffected.
- **Reset:**
  - State→IDLE; accumulators and all outputs →0; overrun→0.
  - A reset mid-sequence aborts it with no sample_valid.
  - Reset wins over a coincident ce_1m.
- Inputs are sampled only at the capture edge. Later input changes do not affect the current sample.

## Timing
- Edge E0: ce_1m captured in IDLE.
- E1–E3 execute V0–V2, E4 executes MIX, E5 executes VOL.
- Outputs and sample_valid are registered at E5. sample_valid is high for exactly the cycle after E5.
- Latency is 6 clocks, tick to valid. Minimum tick spacing without overrun is 6 clocks: a tick on the cycle after E5 (state IDLE) is accepted.
- busy is high from the cycle after E0 through the cycle before IDLE. It is low in the cycle sample_valid is high.
- Outputs hold between samples.

## Structure
- Package `sid_dca_pkg` holds:
  - state enum
  - constants WAVE_W=12, ENV_W=8, ACC_W=14, OUT_W=16, WAVE_MID=2048
- Sub-module `sid_voice_mul`: combinational offset-removal, signed×unsigned multiply, and >>>8 scaling. It has one instance. The VOL multiply reuses a separate small 15×4 product in the top level.

## Test plan
- **Full-scale direct mix.** All wave=0xFFF, env=0xFF, filt_en=0, voice3_off=0, volume=15, filter_return=0; one tick. Expect at E5+1: direct_sum=6117, filter_sum=0, audio_out=5734, sample_valid for 1 cycle.
- **Negative extreme.** All wave=0x000, env=0xFF, volume=15. Expect direct_sum=−6120 and audio_out=−5738.
- **Voice 3 routing.**
  - voice3_off=1, filt_en=0, full-scale as above: expect direct_sum=4078.
  - Then filt_en=3'b100: expect direct_sum=4078, filter_sum=2039.
- **Overrun.** Ticks at clocks 0 and 3. Expect exactly one sample_valid at clock 6 and overrun=1 from clock 4 on. A tick at clock 6 is accepted with no further overrun change.
- **Reset mid-sequence.** Assert reset in state V1. Expect next cycle: busy=0, all outputs 0, no sample_valid. The next tick produces a correct sample.
- **Volume/return.** wave=0x800 for all voices, filter_return=1000, volume=8. Expect direct_sum=0 and audio_out=500.

Source files
------------

// File: rtl/sid_dca_pkg.sv
// Shared widths and FSM encoding for the three-voice SID amplitude/mix scheduler.
package sid_dca_pkg;

  localparam int WAVE_W   = 12;
  localparam int ENV_W    = 8;
  localparam int ACC_W    = 14;
  localparam int OUT_W    = 16;
  localparam int WAVE_MID = 2048;
  localparam int PROD_W   = WAVE_W + ENV_W;
  localparam int MIX_W    = ACC_W + 1;
  localparam int VOL_W    = 4;
  localparam int RET_W    = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V0,
    ST_V1,
    ST_V2,
    ST_MIX,
    ST_VOL
  } state_t;

endpackage

// File: rtl/sid_voice_mul.sv
// Shared voice amplitude stage: removes the waveform DC offset and scales by the envelope.
// Purely combinational; the level is floor((wave-2048)*env / 256).
module sid_voice_mul
  import sid_dca_pkg::*;
(
  input  logic [WAVE_W-1:0]        wave,
  input  logic [ENV_W-1:0]         env,
  output logic signed [WAVE_W-1:0] level
);

  logic signed [WAVE_W-1:0] s;
  logic signed [PROD_W-1:0] s_x;
  logic signed [PROD_W-1:0] e_x;
  logic signed [PROD_W-1:0] p;

  always_comb begin
    s     = signed'(wave - WAVE_W'(WAVE_MID));
    s_x   = {{(PROD_W-WAVE_W){s[WAVE_W-1]}}, s};
    e_x   = {{(PROD_W-ENV_W){1'b0}}, env};
    p     = s_x * e_x;
    level = WAVE_W'(p >>> ENV_W);
  end

endmodule

// File: rtl/sid_dca_scheduler.sv
// Time-multiplexed wave x envelope mixer for three SID voices plus master volume.
// 6 clocks tick-to-valid; ticks arriving while busy are dropped and flagged as overrun.
module sid_dca_scheduler
  import sid_dca_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ce_1m,
  input  logic [WAVE_W-1:0]       wave0,
  input  logic [WAVE_W-1:0]       wave1,
  input  logic [WAVE_W-1:0]       wave2,
  input  logic [ENV_W-1:0]        env0,
  input  logic [ENV_W-1:0]        env1,
  input  logic [ENV_W-1:0]        env2,
  input  logic [2:0]              filt_en,
  input  logic                    voice3_off,
  input  logic [VOL_W-1:0]        volume,
  input  logic signed [RET_W-1:0] filter_return,
  output logic signed [ACC_W-1:0] direct_sum,
  output logic signed [ACC_W-1:0] filter_sum,
  output logic signed [OUT_W-1:0] audio_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  state_t                   state;
  logic [WAVE_W-1:0]        wave_q [3];
  logic [ENV_W-1:0]         env_q  [3];
  logic [2:0]               filt_q;
  logic                     v3off_q;
  logic [VOL_W-1:0]         vol_q;
  logic signed [RET_W-1:0]  ret_q;
  logic signed [ACC_W-1:0]  dir_acc;
  logic signed [ACC_W-1:0]  filt_acc;
  logic signed [MIX_W-1:0]  mix;

  logic [1:0]               vidx;
  logic [WAVE_W-1:0]        mul_wave;
  logic [ENV_W-1:0]         mul_env;
  logic signed [WAVE_W-1:0] mul_v;
  logic signed [ACC_W-1:0]  v_ext;
  logic signed [MIX_W+VOL_W-1:0] mix_x;
  logic signed [MIX_W+VOL_W-1:0] vol_x;
  logic signed [MIX_W+VOL_W-1:0] vol_prod;

  // Outside the voice states the multiplier sees a zero-level input so it stays quiet.
  always_comb begin
    vidx     = 2'd0;
    mul_wave = WAVE_W'(WAVE_MID);
    mul_env  = '0;
    case (state)
      ST_V0: begin vidx = 2'd0; mul_wave = wave_q[0]; mul_env = env_q[0]; end
      ST_V1: begin vidx = 2'd1; mul_wave = wave_q[1]; mul_env = env_q[1]; end
      ST_V2: begin vidx = 2'd2; mul_wave = wave_q[2]; mul_env = env_q[2]; end
      default: ;
    endcase
    v_ext    = {{(ACC_W-WAVE_W){mul_v[WAVE_W-1]}}, mul_v};
    mix_x    = {{VOL_W{mix[MIX_W-1]}}, mix};
    vol_x    = {{MIX_W{1'b0}}, vol_q};
    vol_prod = mix_x * vol_x;
  end

  sid_voice_mul u_mul (
    .wave  (mul_wave),
    .env   (mul_env),
    .level (mul_v)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      for (int i = 0; i < 3; i++) begin
        wave_q[i] <= '0;
        env_q[i]  <= '0;
      end
      filt_q       <= '0;
      v3off_q      <= 1'b0;
      vol_q        <= '0;
      ret_q        <= '0;
      dir_acc      <= '0;
      filt_acc     <= '0;
      mix          <= '0;
      direct_sum   <= '0;
      filter_sum   <= '0;
      audio_out    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (ce_1m && state != ST_IDLE)
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ce_1m) begin
            wave_q[0] <= wave0;
            wave_q[1] <= wave1;
            wave_q[2] <= wave2;
            env_q[0]  <= env0;
            env_q[1]  <= env1;
            env_q[2]  <= env2;
            filt_q    <= filt_en;
            v3off_q   <= voice3_off;
            vol_q     <= volume;
            ret_q     <= filter_return;
            dir_acc   <= '0;
            filt_acc  <= '0;
            busy      <= 1'b1;
            state     <= ST_V0;
          end
        end
        ST_V0, ST_V1, ST_V2: begin
          // voice3_off only silences the direct path; a filtered voice 3 still reaches the filter.
          if (filt_q[vidx])
            filt_acc <= filt_acc + v_ext;
          else if (!(state == ST_V2 && v3off_q))
            dir_acc <= dir_acc + v_ext;
          state <= (state == ST_V0) ? ST_V1 : (state == ST_V1) ? ST_V2 : ST_MIX;
        end
        ST_MIX: begin
          mix   <= {dir_acc[ACC_W-1], dir_acc} + {ret_q[RET_W-1], ret_q};
          state <= ST_VOL;
        end
        ST_VOL: begin
          audio_out    <= OUT_W'(vol_prod >>> VOL_W);
          direct_sum   <= dir_acc;
          filter_sum   <= filt_acc;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sid_dca_scheduler.sv
// Bench for sid_dca_scheduler: vector table through a scoreboard, plus overrun and reset sequences.
module tb_sid_dca_scheduler;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               ce_1m = 1'b0;
  logic [11:0]        wave0 = '0, wave1 = '0, wave2 = '0;
  logic [7:0]         env0 = '0, env1 = '0, env2 = '0;
  logic [2:0]         filt_en = '0;
  logic               voice3_off = 1'b0;
  logic [3:0]         volume = '0;
  logic signed [13:0] filter_return = '0;
  logic signed [13:0] direct_sum, filter_sum;
  logic signed [15:0] audio_out;
  logic               sample_valid, busy, overrun;

  sid_dca_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .ce_1m         (ce_1m),
    .wave0         (wave0),
    .wave1         (wave1),
    .wave2         (wave2),
    .env0          (env0),
    .env1          (env1),
    .env2          (env2),
    .filt_en       (filt_en),
    .voice3_off    (voice3_off),
    .volume        (volume),
    .filter_return (filter_return),
    .direct_sum    (direct_sum),
    .filter_sum    (filter_sum),
    .audio_out     (audio_out),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0][11:0]   wave;
    logic [2:0][7:0]    env;
    logic [2:0]         filt;
    logic               off;
    logic [3:0]         vol;
    logic signed [13:0] ret;
    int                 d;
    int                 f;
    int                 a;
  } vec_t;

  typedef struct { int d; int f; int a; } exp_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;
  int   sv_count = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && sample_valid) begin
      exp_t e;
      sv_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        e = sb.pop_front();
        check("direct_sum", int'(direct_sum), e.d);
        check("filter_sum", int'(filter_sum), e.f);
        check("audio_out", int'(audio_out), e.a);
      end
    end
  end

  function automatic vec_t mk(input logic [11:0] w, input logic [7:0] e, input logic [2:0] fe,
                              input logic off, input logic [3:0] vol, input int ret,
                              input int d, input int f, input int a);
    vec_t r;
    r.wave = {w, w, w};
    r.env  = {e, e, e};
    r.filt = fe;
    r.off  = off;
    r.vol  = vol;
    r.ret  = 14'(ret);
    r.d = d; r.f = f; r.a = a;
    return r;
  endfunction

  function automatic vec_t model(input vec_t r);
    vec_t o = r;
    int s, v, m;
    o.d = 0;
    o.f = 0;
    for (int n = 0; n < 3; n++) begin
      s = int'(r.wave[n]) - 2048;
      v = (s * int'(r.env[n])) >>> 8;
      if (r.filt[n]) o.f += v;
      else if (!(n == 2 && r.off)) o.d += v;
    end
    m = o.d + int'(r.ret);
    o.a = (m * int'(r.vol)) >>> 4;
    return o;
  endfunction

  task automatic apply(input vec_t r);
    wave0 = r.wave[0]; wave1 = r.wave[1]; wave2 = r.wave[2];
    env0 = r.env[0]; env1 = r.env[1]; env2 = r.env[2];
    filt_en = r.filt; voice3_off = r.off; volume = r.vol; filter_return = r.ret;
  endtask

  task automatic scramble();
    wave0 = 12'($urandom); wave1 = 12'($urandom); wave2 = 12'($urandom);
    env0 = 8'($urandom); env1 = 8'($urandom); env2 = 8'($urandom);
    filt_en = 3'($urandom); voice3_off = 1'($urandom);
    volume = 4'($urandom); filter_return = 14'($urandom);
  endtask

  task automatic push(input vec_t r);
    exp_t e;
    e.d = r.d; e.f = r.f; e.a = r.a;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t r);
    apply(r);
    ce_1m = 1'b1;
    push(r);
    step();
    ce_1m = 1'b0;
    scramble();
    drain();
  endtask

  initial begin
    int sv0;
    vec_t rv;
    tbl[0] = mk(12'hFFF, 8'hFF, 3'b000, 1'b0, 4'd15, 0, 6117, 0, 5734);
    tbl[1] = mk(12'h000, 8'hFF, 3'b000, 1'b0, 4'd15, 0, -6120, 0, -5738);
    tbl[2] = mk(12'hFFF, 8'hFF, 3'b000, 1'b1, 4'd15, 0, 4078, 0, 3823);
    tbl[3] = mk(12'hFFF, 8'hFF, 3'b100, 1'b1, 4'd15, 0, 4078, 2039, 3823);
    tbl[4] = mk(12'h800, 8'hFF, 3'b000, 1'b0, 4'd8, 1000, 0, 0, 500);
    tbl[5] = mk(12'h800, 8'hFF, 3'b000, 1'b0, 4'd15, -8192, 0, 0, -7680);
    tbl[6] = mk(12'hFFF, 8'hFF, 3'b000, 1'b0, 4'd0, 0, 6117, 0, 0);
    tbl[7] = mk(12'h000, 8'hFF, 3'b111, 1'b0, 4'd15, -1000, 0, -6120, -938);
    for (int i = 8; i < 14; i++) begin
      rv.wave = {12'($urandom), 12'($urandom), 12'($urandom)};
      rv.env  = {8'($urandom), 8'($urandom), 8'($urandom)};
      rv.filt = 3'($urandom);
      rv.off  = 1'($urandom);
      rv.vol  = 4'($urandom);
      rv.ret  = 14'($urandom);
      tbl[i]  = model(rv);
    end

    // Reset held across a tick: the tick must not start a sequence.
    repeat (3) step();
    ce_1m = 1'b1;
    step();
    reset = 1'b0;
    ce_1m = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_direct", int'(direct_sum), 0);
    check("reset_filter", int'(filter_sum), 0);
    check("reset_audio", int'(audio_out), 0);
    step();
    check("reset_tick_ignored", int'(busy), 0);

    for (int i = 0; i < 14; i++) run_vec(tbl[i]);
    check("no_overrun_at_min_spacing", int'(overrun), 0);

    // Overrun: ticks at clocks 0 and 3, then a legal tick at clock 6.
    sv0 = sv_count;
    apply(tbl[0]);
    ce_1m = 1'b1;
    push(tbl[0]);
    step();
    ce_1m = 1'b0;
    check("busy_after_capture", int'(busy), 1);
    step();
    step();
    check("overrun_before", int'(overrun), 0);
    apply(tbl[1]);
    ce_1m = 1'b1;
    step();
    ce_1m = 1'b0;
    check("overrun_set", int'(overrun), 1);
    check("busy_during_overrun", int'(busy), 1);
    step();
    check("valid_not_early", int'(sample_valid), 0);
    step();
    check("valid_at_6", int'(sample_valid), 1);
    check("busy_low_in_valid", int'(busy), 0);
    apply(tbl[4]);
    ce_1m = 1'b1;
    push(tbl[4]);
    step();
    ce_1m = 1'b0;
    scramble();
    check("valid_one_cycle", int'(sample_valid), 0);
    check("tick6_accepted", int'(busy), 1);
    check("single_valid_so_far", sv_count - sv0, 1);
    check("overrun_sticky", int'(overrun), 1);
    drain();
    check("two_valids_total", sv_count - sv0, 2);

    // Reset while in V1 aborts the sample.
    apply(tbl[1]);
    ce_1m = 1'b1;
    push(tbl[1]);
    step();
    ce_1m = 1'b0;
    step();
    reset = 1'b1;
    step();
    sb.delete();
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(sample_valid), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_direct", int'(direct_sum), 0);
    check("midrst_filter", int'(filter_sum), 0);
    check("midrst_audio", int'(audio_out), 0);
    reset = 1'b0;
    sv0 = sv_count;
    repeat (8) step();
    check("midrst_no_valid", sv_count - sv0, 0);
    run_vec(tbl[3]);
    run_vec(tbl[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
